// File: rtl/mem_bus_master.sv
// Burst initiator for the single-port memory: turns ready/valid burst commands
// into wr/rd bus cycles and owns the turnaround of the shared data bus.
module mem_bus_master #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8,
    parameter int LWIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [LWIDTH-1:0] cmd_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DWIDTH-1:0] wdata,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic [DWIDTH-1:0] rdata,
    output logic              busy,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [AWIDTH-1:0] mem_addr,
    inout  wire  [DWIDTH-1:0] mem_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_TURN = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_RD   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [LWIDTH-1:0] cnt_q, cnt_d;
    logic              last_rd_q, last_rd_d;
    logic              rvalid_q, rvalid_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic              wr_s;
    logic              rd_s;

    // Bus strobes; a read is only issued when the output register can take the word.
    always_comb begin
        wr_s = !rst && (state_q == S_WR) && wdata_valid;
        rd_s = !rst && (state_q == S_RD) && (!rvalid_q || rdata_ready);
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        last_rd_d = last_rd_q;
        rdata_d   = rdata_q;
        if (rvalid_q && rdata_ready) begin
            rvalid_d = 1'b0;
        end else begin
            rvalid_d = rvalid_q;
        end
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d = cmd_addr;
                    cnt_d  = cmd_len;
                    if (!cmd_we) begin
                        state_d = S_RD;
                    end else if (last_rd_q) begin
                        state_d = S_TURN;
                    end else begin
                        state_d = S_WR;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_TURN: begin
                last_rd_d = 1'b0;
                state_d   = S_WR;
            end
            S_WR: begin
                if (wr_s) begin
                    addr_d = addr_q + 1'b1;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == {LWIDTH{1'b0}}) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WR;
                    end
                end else begin
                    state_d = S_WR;
                end
            end
            S_RD: begin
                if (rd_s) begin
                    rdata_d  = mem_data;
                    rvalid_d = 1'b1;
                    addr_d   = addr_q + 1'b1;
                    cnt_d    = cnt_q - 1'b1;
                    // Remember the read so a following write gets a Z cycle first.
                    if (cnt_q == {LWIDTH{1'b0}}) begin
                        state_d   = S_IDLE;
                        last_rd_d = 1'b1;
                    end else begin
                        state_d = S_RD;
                    end
                end else begin
                    state_d = S_RD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset abandons any burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= {AWIDTH{1'b0}};
            cnt_q     <= {LWIDTH{1'b0}};
            last_rd_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= {DWIDTH{1'b0}};
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            last_rd_q <= last_rd_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    assign cmd_ready   = !rst && (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign wdata_ready = (state_q == S_WR);
    assign mem_wr      = wr_s;
    assign mem_rd      = rd_s;
    assign mem_addr    = addr_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rvalid_q;
    assign mem_data    = wr_s ? wdata : {DWIDTH{1'bz}};

endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
- Initiator for the team's single-port memory (wr/rd/addr plus a bidirectional data bus; synchronous write, asynchronous read).
- Converts ready/valid burst commands into memory bus cycles.
- Streams write data in and read data out.
- Sits between a client (CPU load/store unit or DMA) and the memory instance, and owns bus turnaround so the master never drives the data bus while the memory does.

Parameters:
AWIDTH, 5, memory address width (2**AWIDTH words)
DWIDTH, 8, data word width
LWIDTH, 4, burst length field width; beats = cmd_len+1 (1..2**LWIDTH)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when cmd_valid&cmd_ready
cmd_we  input  1  1=write burst, 0=read burst
cmd_addr  input  AWIDTH  start address
cmd_len  input  LWIDTH  beats minus one
wdata_valid  input  1  write beat offered
wdata_ready  output  1  write beat accepted
wdata  input  DWIDTH  write beat data
rdata_valid  output  1  read beat available
rdata_ready  input  1  consumer takes read beat
rdata  output  DWIDTH  read beat data
busy  output  1  command in progress (state != IDLE)
mem_wr  output  1  memory write enable
mem_rd  output  1  memory read enable
mem_addr  output  AWIDTH  memory address
mem_data  inout  DWIDTH  memory data bus

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE, cmd_ready=0 during reset, busy=0, mem_wr=0, mem_rd=0, mem_addr=0, mem_data=Z, rdata_valid=0, rdata=0, last_was_read=0. Reset mid-burst abandons the burst; no further bus cycles are issued.
- States: IDLE, TURN, WR, RD.
- IDLE: cmd_ready=1. On accept: latch addr into mem_addr and cmd_len into beat counter.
  - cmd_we=0 -> RD.
  - cmd_we=1 with last_was_read=1 -> TURN.
  - Otherwise cmd_we=1 -> WR.
- TURN: one cycle with mem_wr=mem_rd=0 and mem_data=Z; clears last_was_read; -> WR.
- WR: wdata_ready=1.
  - mem_wr = wdata_valid (combinational). mem_data = wdata while mem_wr=1, else Z.
  - The memory captures the word at the posedge ending that cycle.
  - On each accepted beat: mem_addr++ and counter--. The beat with counter==0 -> IDLE.
  - wdata_valid=0 stalls without a bus cycle.
- RD: mem_rd = !rdata_valid | rdata_ready (combinational). mem_data is never driven by the master.
  - At the posedge with mem_rd=1: rdata<=mem_data, rdata_valid<=1, mem_addr++, counter--.
  - Last beat -> IDLE and set last_was_read=1.
  - rdata_valid clears when rdata_ready=1 and no new capture occurs that cycle.
  - Sustains 1 beat/cycle with rdata_ready held high.
- rdata_valid may remain 1 after return to IDLE. A following read command still gates mem_rd on the output register, so no beat is lost.
- Address arithmetic is modulo 2**AWIDTH: address 2**AWIDTH-1 increments to 0.
- Invariants:
  - mem_wr & mem_rd never both 1.
  - mem_data driven only when mem_wr=1.
  - A write never directly follows a read cycle (at least one Z cycle between them).
- Latency:
  - Write beat: stored at the same edge it is accepted.
  - Read beat: rdata_valid 1 cycle after mem_rd is asserted.
  - Command accept to first bus cycle: 1 cycle, or 2 cycles with TURN.
- cmd_valid while busy: ignored, cmd_ready=0.
- Fields: cmd_len=0 is a single beat; cmd_len=2**LWIDTH-1 is the maximum burst.

Test Plan:
- Write burst, addr=3, len=3, data 0xA1..0xA4 with wdata_valid held high -> mem_wr high 4 consecutive cycles, memory[3..6]=A1..A4, busy falls after the 4th beat.
- Read burst of the same region with rdata_ready=1 -> rdata sequence A1,A2,A3,A4 on 4 consecutive cycles; mem_data never driven by the master.
- Wrap: write len=2 at addr=31 with 0x11,0x22,0x33, then read len=2 at addr=31 -> reads 11,22,33; memory[0]=0x22, memory[1]=0x33.
- Backpressure: read len=3 with rdata_ready toggling 1,0,0,1,... -> mem_rd low whenever rdata_valid=1 and rdata_ready=0; all 4 beats delivered in order, none duplicated.
- Turnaround: read len=0 immediately followed by write len=0 -> exactly one TURN cycle with mem_wr=mem_rd=0 and mem_data=Z before mem_wr rises; checker flags any mem_wr&mem_rd overlap.
- Reset mid-write: write len=7, assert rst after beat 2 -> next cycle mem_wr=0, busy=0, cmd_ready=1 after rst drops; only 2 words modified.
